// File: rtl/rpn_seq_pkg.sv
// rpn_seq_pkg: shared FSM states, calculator opcodes and error codes for the RPN program sequencer
package rpn_seq_pkg;
  typedef enum logic [2:0] {IDLE, CLR, ISSUE, CHECK, DONE, ERR} state_t;
  localparam logic [3:0] OP_INC  = 4'd0;
  localparam logic [3:0] OP_DEC  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_DUP  = 4'd6;
  localparam logic [3:0] OP_PUSH = 4'd7;
  localparam logic [3:0] OP_POP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CALC  = 2'd1;
  localparam logic [1:0] ERR_PC    = 2'd2;
  localparam logic [1:0] ERR_EMPTY = 2'd3;
endpackage

// File: rtl/rpn_prog_mem.sv
// rpn_prog_mem: DEPTH x (4+W) program register file, one sync write port, one async read port.
//   clk, i_we/i_waddr/i_wdata write port, i_raddr/o_rdata combinational read port.
//   Contents are intentionally not reset.
module rpn_prog_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [3+W:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [3+W:0]  o_rdata
);
  logic [3+W:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/rpn_program_sequencer.sv
// rpn_program_sequencer: runs a stored RPN program on the stack calculator and reports the outcome.
//   Host side: i_prog_we/i_prog_addr/i_prog_data load the program (ignored while busy), i_start runs it,
//   o_busy/o_done/o_result/o_error/o_err_pc report. Calc side: o_calc_rst/o_calc_op/o_calc_in/o_calc_apply
//   drive the calculator, i_calc_head/i_calc_empty/i_calc_valid observe it.
//   Optional RPN_SEQ_SINGLE_STEP_EN adds i_step/i_mode: with i_mode=1 each rising edge of i_step lets
//   exactly one instruction (or the HALT) go through ISSUE; otherwise the program free-runs.
module rpn_program_sequencer
  import rpn_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef RPN_SEQ_SINGLE_STEP_EN
  input  logic          i_step,
  input  logic          i_mode,
`endif
  input  logic          i_prog_we,
  input  logic [AW-1:0] i_prog_addr,
  input  logic [3+W:0]  i_prog_data,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [W-1:0]  o_result,
  output logic [1:0]    o_error,
  output logic [AW-1:0] o_err_pc,
  output logic          o_calc_rst,
  output logic [3:0]    o_calc_op,
  output logic [W-1:0]  o_calc_in,
  output logic          o_calc_apply,
  input  logic [W-1:0]  i_calc_head,
  input  logic          i_calc_empty,
  input  logic          i_calc_valid
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t        r_state, w_next;
  logic [AW-1:0] r_pc;
  logic [3+W:0]  w_word;
  logic [3:0]    w_op;
  logic [W-1:0]  w_arg;
  logic          w_go, w_issue;
  rpn_prog_mem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (i_prog_we && !o_busy),
    .i_waddr (i_prog_addr),
    .i_wdata (i_prog_data),
    .i_raddr (r_pc),
    .o_rdata (w_word)
  );
  assign w_op  = w_word[3+W:W];
  assign w_arg = w_word[W-1:0];
`ifdef RPN_SEQ_SINGLE_STEP_EN
  logic r_step_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_step_d <= 1'b0;
    else        r_step_d <= i_step;
  assign w_go = !i_mode || (i_step && !r_step_d);
`else
  assign w_go = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: w_next = i_start ? CLR : r_state;
      CLR:             w_next = ISSUE;
      ISSUE:           w_next = !w_go ? ISSUE : (w_op != OP_HALT) ? CHECK : i_calc_empty ? ERR : DONE;
      CHECK:           w_next = (!i_calc_valid || r_pc == LAST) ? ERR : ISSUE;
      default:         w_next = IDLE;
    endcase
  end
  always_comb begin
    w_issue      = r_state == ISSUE && w_go && w_op != OP_HALT;
    o_busy       = r_state == CLR || r_state == ISSUE || r_state == CHECK;
    o_calc_rst   = r_state == IDLE || r_state == CLR;
    o_calc_apply = w_issue;
    o_calc_op    = w_issue ? w_op : 4'd0;
    o_calc_in    = w_issue ? w_arg : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc     <= '0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_error  <= ERR_NONE;
      o_err_pc <= '0;
    end else begin
      o_done <= o_busy && (w_next == DONE || w_next == ERR);
      case (r_state)
        CLR: begin
          r_pc     <= '0;
          o_error  <= ERR_NONE;
          o_err_pc <= '0;
        end
        ISSUE:
          if (w_go && w_op == OP_HALT) begin
            if (i_calc_empty) begin
              o_error  <= ERR_EMPTY;
              o_err_pc <= r_pc;
            end else
              o_result <= i_calc_head;
          end
        CHECK:
          if (!i_calc_valid || r_pc == LAST) begin
            o_error  <= !i_calc_valid ? ERR_CALC : ERR_PC;
            o_err_pc <= r_pc;
          end else
            r_pc <= r_pc + 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rpn_program_sequencer.sv
// tb_rpn_program_sequencer: directed self-checking bench with a behavioural 11-deep stack calculator
module tb_rpn_program_sequencer;
  import rpn_seq_pkg::*;
  logic       clk = 0, rst_n = 0;
  logic       we = 0, start = 0;
  logic [3:0] addr = 0;
  logic [11:0] data = 0;
  logic       busy, done, c_rst, c_apply;
  logic [7:0] result, c_in, c_head;
  logic [1:0] error;
  logic [3:0] err_pc, c_op;
  logic       c_empty, c_valid;
  int n_cmp = 0, n_bad = 0, n_apply = 0, n_done = 0;
  always #5 clk = ~clk;
  rpn_program_sequencer #(.W(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RPN_SEQ_SINGLE_STEP_EN
    .i_step(1'b0), .i_mode(1'b0),
`endif
    .i_prog_we(we), .i_prog_addr(addr), .i_prog_data(data), .i_start(start),
    .o_busy(busy), .o_done(done), .o_result(result), .o_error(error), .o_err_pc(err_pc),
    .o_calc_rst(c_rst), .o_calc_op(c_op), .o_calc_in(c_in), .o_calc_apply(c_apply),
    .i_calc_head(c_head), .i_calc_empty(c_empty), .i_calc_valid(c_valid)
  );
  logic [7:0] stk [0:10];
  int sp = 0;
  logic cv = 1;
  always_ff @(posedge clk)
    if (c_rst) begin
      sp <= 0;
      cv <= 1'b1;
    end else if (c_apply)
      case (c_op)
        OP_PUSH: if (sp == 11) cv <= 1'b0; else begin stk[sp] <= c_in; sp <= sp + 1; end
        OP_POP:  if (sp == 0) cv <= 1'b0; else sp <= sp - 1;
        OP_INC:  if (sp == 0) cv <= 1'b0; else stk[sp-1] <= stk[sp-1] + 8'd1;
        OP_DUP:  if (sp == 0 || sp == 11) cv <= 1'b0; else begin stk[sp] <= stk[sp-1]; sp <= sp + 1; end
        OP_ADD:  if (sp < 2) cv <= 1'b0; else begin stk[sp-2] <= stk[sp-2] + stk[sp-1]; sp <= sp - 1; end
        OP_SUB:  if (sp < 2) cv <= 1'b0; else begin stk[sp-2] <= stk[sp-2] - stk[sp-1]; sp <= sp - 1; end
        OP_DIV:  if (sp < 2 || stk[sp-1] == 0) cv <= 1'b0;
                 else begin stk[sp-2] <= stk[sp-2] / stk[sp-1]; sp <= sp - 1; end
        default: cv <= 1'b0;
      endcase
  assign c_empty = sp == 0;
  assign c_valid = cv;
  assign c_head  = sp == 0 ? 8'd0 : stk[sp-1];
  always @(posedge clk) begin
    if (c_apply) n_apply++;
    if (done) n_done++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wr(input int a, input logic [3:0] op, input logic [7:0] v);
    @(negedge clk);
    we = 1; addr = 4'(a); data = {op, v};
    @(posedge clk);
    #1 we = 0;
  endtask
  task automatic run(input string tag, input int exp_cyc, input logic [1:0] exp_err,
                     input logic [3:0] exp_pc, input logic [7:0] exp_res, input int exp_apply);
    int a0, cyc;
    @(negedge clk);
    start = 1;
    a0 = n_apply;
    @(posedge clk);
    #1 start = 0;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, ".cycles"}, cyc, exp_cyc);
    chk({tag, ".error"}, error, exp_err);
    chk({tag, ".err_pc"}, err_pc, exp_pc);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".applies"}, n_apply - a0, exp_apply);
    chk({tag, ".busy"}, busy, 0);
    @(posedge clk);
    #1 chk({tag, ".done_pulse"}, done, 0);
  endtask
  initial begin
    int d0;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.calc_rst", c_rst, 1);
    chk("rst.apply", c_apply, 0);
    chk("rst.result", result, 0);
    chk("rst.error", error, 0);
    chk("rst.err_pc", err_pc, 0);
    chk("rst.calc_op", c_op, 0);
    chk("rst.calc_in", c_in, 0);
    @(negedge clk) rst_n = 1;
    wr(0, OP_PUSH, 3); wr(1, OP_PUSH, 4); wr(2, OP_ADD, 0); wr(3, OP_HALT, 0);
    run("add", 8, ERR_NONE, 0, 7, 3);
    wr(0, OP_PUSH, 5); wr(1, OP_PUSH, 0); wr(2, OP_DIV, 0); wr(3, OP_HALT, 0);
    run("div0", 7, ERR_CALC, 2, 7, 3);
    for (int i = 0; i < 12; i++) wr(i, OP_PUSH, 1);
    wr(12, OP_HALT, 0);
    run("ovf", 25, ERR_CALC, 11, 7, 12);
    wr(0, OP_HALT, 0);
    run("halt", 2, ERR_EMPTY, 0, 7, 0);
    for (int i = 0; i < 16; i++) wr(i, i[0] ? OP_POP : OP_PUSH, 8'(i));
    fork
      run("runoff", 33, ERR_PC, 15, 7, 16);
      begin
        repeat (5) @(posedge clk);
        wr(0, OP_HALT, 0);
      end
    join
    run("runoff2", 33, ERR_PC, 15, 7, 16);
    wr(0, OP_PUSH, 3); wr(1, OP_PUSH, 4); wr(2, OP_ADD, 0); wr(3, OP_HALT, 0);
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #1 d0 = n_done;
    rst_n = 0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.calc_rst", c_rst, 1);
    chk("midrst.apply", c_apply, 0);
    chk("midrst.result", result, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (5) @(posedge clk);
    #1 chk("midrst.no_done", n_done - d0, 0);
    chk("midrst.idle", busy, 0);
    run("rerun", 8, ERR_NONE, 0, 7, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
